shift_line: RTL and testbench

Parametrised multi-bit shift/delay line that generalises the single-bit serial shift register to WIDTH-bit words with per-stage valid tracking. It adds run-time mode control (hold, forward shift, backward shift, rotate), a synchronous clear, a selectable tap output and a fill count. It sits wherever the design needs a programmable delay, a sample window or a rotating word buffer. With WIDTH=1 and mode fixed at forward shift, data_out matches a plain DEPTH-stage serial shift register.

---
 rtl/shift_line.sv | 97 +++++++++
 tb/tb_shift_line.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shift_line.sv
// Programmable WIDTH-bit delay line with per-stage valid bits, run-time
// shift direction / rotate, synchronous clear, selectable tap and fill count.
module shift_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int TW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] tap_out,
    output logic             tap_valid,
    output logic [CW-1:0]    fill,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_FWD  = 2'b01,
        MODE_BWD  = 2'b10,
        MODE_ROT  = 2'b11
    } mode_e;

    mode_e mode_s;
    assign mode_s = mode_e'(mode);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [DEPTH-1:0]            valid_q, valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            valid_q <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
        end
    end

    // clear outranks en, which outranks mode
    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        if (clear) begin
            stage_d = '0;
            valid_d = '0;
        end else if (en) begin
            case (mode_s)
                MODE_FWD: begin
                    stage_d[0] = data_in;
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                    valid_d = {valid_q[DEPTH-2:0], 1'b1};
                end
                MODE_BWD: begin
                    stage_d[DEPTH-1] = data_in;
                    for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
                    valid_d = {1'b1, valid_q[DEPTH-1:1]};
                end
                MODE_ROT: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                    valid_d = {valid_q[DEPTH-2:0], valid_q[DEPTH-1]};
                end
                default: ;
            endcase
        end
    end

    // Matching against each legal index leaves out-of-range selects at zero
    always_comb begin
        tap_out   = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_out   = stage_q[i];
                tap_valid = valid_q[i];
            end
        end
    end

    always_comb begin
        fill = '0;
        for (int i = 0; i < DEPTH; i++) fill = fill + CW'(valid_q[i]);
    end

    assign data_out = stage_q[DEPTH-1];
    assign full     = (fill == CW'(DEPTH));
    assign empty    = ~|valid_q;

endmodule

// File: tb/tb_shift_line.sv
// Directed bench for shift_line: a DEPTH=4 and a DEPTH=5 instance, expected
// outputs queued by the stimulus and popped by a negedge monitor.
module tb_shift_line;

    logic clk;
    logic reset;

    logic       en4, clr4;
    logic [1:0] mode4;
    logic [7:0] din4;
    logic [1:0] tap4;
    logic [7:0] do4, to4;
    logic       tv4, full4, empty4;
    logic [2:0] fill4;

    logic       en5, clr5;
    logic [1:0] mode5;
    logic [7:0] din5;
    logic [2:0] tap5;
    logic [7:0] do5, to5;
    logic       tv5, full5, empty5;
    logic [2:0] fill5;

    shift_line #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .en(en4), .clear(clr4), .mode(mode4),
        .data_in(din4), .tap_sel(tap4), .data_out(do4), .tap_out(to4),
        .tap_valid(tv4), .fill(fill4), .full(full4), .empty(empty4)
    );

    shift_line #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .reset(reset), .en(en5), .clear(clr5), .mode(mode5),
        .data_in(din5), .tap_sel(tap5), .data_out(do5), .tap_out(to5),
        .tap_valid(tv5), .fill(fill5), .full(full5), .empty(empty5)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {sel, data_out, tap_out, tap_valid, fill[3:0], full, empty}
    logic [23:0] exp_q[$];
    string       name_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic [23:0] pack(input logic sel, input logic [7:0] d,
                                         input logic [7:0] t, input logic tv,
                                         input logic [3:0] f, input logic fu,
                                         input logic em);
        return {sel, d, t, tv, f, fu, em};
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [23:0] e, a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (e[23] == 1'b0)
                a = pack(1'b0, do4, to4, tv4, {1'b0, fill4}, full4, empty4);
            else
                a = pack(1'b1, do5, to5, tv5, {1'b0, fill5}, full5, empty5);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got do=%h tap=%h tv=%b fill=%0d full=%b empty=%b, want do=%h tap=%h tv=%b fill=%0d full=%b empty=%b",
                         n, a[22:15], a[14:7], a[6], a[5:2], a[1], a[0],
                         e[22:15], e[14:7], e[6], e[5:2], e[1], e[0]);
            end
        end
    end

    // driver tasks
    task automatic step(input logic sel, input logic e, input logic c,
                        input logic [1:0] m, input logic [7:0] d);
        if (!sel) begin en4 = e; clr4 = c; mode4 = m; din4 = d; end
        else      begin en5 = e; clr5 = c; mode5 = m; din5 = d; end
        @(posedge clk);
        #1;
        en4 = 1'b0; clr4 = 1'b0; mode4 = 2'b00;
        en5 = 1'b0; clr5 = 1'b0; mode5 = 2'b00;
    endtask

    task automatic chk(input string name, input logic sel, input int tap,
                       input logic [7:0] d, input logic [7:0] t, input logic tv,
                       input int f, input logic fu, input logic em);
        if (!sel) tap4 = 2'(tap);
        else      tap5 = 3'(tap);
        exp_q.push_back(pack(sel, d, t, tv, 4'(f), fu, em));
        name_q.push_back(name);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en4 = 0; clr4 = 0; mode4 = 0; din4 = 0; tap4 = 0;
        en5 = 0; clr5 = 0; mode5 = 0; din5 = 0; tap5 = 0;
        #2;
        chk("reset_state", 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
        chk("reset_state5", 1, 0, 8'h00, 8'h00, 0, 0, 0, 1);
        reset = 1'b0;

        // forward fill
        step(0, 1, 0, 2'b01, 8'h11);
        chk("fwd1", 0, 0, 8'h00, 8'h11, 1, 1, 0, 0);
        step(0, 1, 0, 2'b01, 8'h22);
        chk("fwd2", 0, 1, 8'h00, 8'h11, 1, 2, 0, 0);
        step(0, 1, 0, 2'b01, 8'h33);
        chk("fwd3", 0, 3, 8'h00, 8'h00, 0, 3, 0, 0);
        step(0, 1, 0, 2'b01, 8'h44);
        chk("fwd4_full", 0, 1, 8'h11, 8'h33, 1, 4, 1, 0);
        step(0, 1, 0, 2'b01, 8'h55);
        chk("fwd_overflow", 0, 0, 8'h22, 8'h55, 1, 4, 1, 0);

        // asynchronous reset pulse between edges
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        chk("async_reset", 0, 1, 8'h00, 8'h00, 0, 0, 0, 1);

        // refill and rotate
        step(0, 1, 0, 2'b01, 8'h11);
        step(0, 1, 0, 2'b01, 8'h22);
        step(0, 1, 0, 2'b01, 8'h33);
        step(0, 1, 0, 2'b01, 8'h44);
        chk("refill", 0, 0, 8'h11, 8'h44, 1, 4, 1, 0);
        step(0, 1, 0, 2'b11, 8'hEE);
        chk("rot1", 0, 0, 8'h22, 8'h11, 1, 4, 1, 0);
        step(0, 1, 0, 2'b11, 8'hEE);
        step(0, 1, 0, 2'b11, 8'hEE);
        step(0, 1, 0, 2'b11, 8'hEE);
        chk("rot4_restored", 0, 2, 8'h11, 8'h22, 1, 4, 1, 0);

        // enable low / mode hold
        step(0, 0, 0, 2'b01, 8'h99);
        step(0, 0, 0, 2'b01, 8'h98);
        step(0, 0, 0, 2'b01, 8'h97);
        chk("en_low_hold", 0, 0, 8'h11, 8'h44, 1, 4, 1, 0);
        step(0, 1, 0, 2'b00, 8'h96);
        chk("mode00_hold", 0, 1, 8'h11, 8'h33, 1, 4, 1, 0);

        // clear with en=1 ignores data_in
        step(0, 1, 1, 2'b01, 8'h99);
        chk("clear_en1", 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);

        // backward shift
        step(0, 1, 0, 2'b10, 8'hA5);
        chk("bwd1", 0, 3, 8'hA5, 8'hA5, 1, 1, 0, 0);
        chk("bwd1_s2", 0, 2, 8'hA5, 8'h00, 0, 1, 0, 0);
        step(0, 1, 0, 2'b10, 8'h5A);
        chk("bwd2_t2", 0, 2, 8'h5A, 8'hA5, 1, 2, 0, 0);
        chk("bwd2_t0", 0, 0, 8'h5A, 8'h00, 0, 2, 0, 0);

        // rotate on a partially valid line: valid bits travel with data
        step(0, 1, 0, 2'b11, 8'hEE);
        chk("rot_part_t0", 0, 0, 8'hA5, 8'h5A, 1, 2, 0, 0);
        chk("rot_part_t1", 0, 1, 8'hA5, 8'h00, 0, 2, 0, 0);

        // clear with en=0 still clears
        step(0, 0, 1, 2'b01, 8'h77);
        chk("clear_en0", 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);

        // DEPTH=5: out-of-range tap selects
        step(1, 1, 0, 2'b01, 8'h01);
        step(1, 1, 0, 2'b01, 8'h02);
        step(1, 1, 0, 2'b01, 8'h03);
        step(1, 1, 0, 2'b01, 8'h04);
        step(1, 1, 0, 2'b01, 8'h05);
        chk("d5_tap5", 1, 5, 8'h01, 8'h00, 0, 5, 1, 0);
        chk("d5_tap6", 1, 6, 8'h01, 8'h00, 0, 5, 1, 0);
        chk("d5_tap7", 1, 7, 8'h01, 8'h00, 0, 5, 1, 0);
        chk("d5_tap4", 1, 4, 8'h01, 8'h01, 1, 5, 1, 0);
        chk("d5_tap0", 1, 0, 8'h01, 8'h05, 1, 5, 1, 0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
